// File: rtl/move_input_ctrl.sv
// move_input_ctrl: upstream input stage of the 2048 game top level.
//   Synchronises and debounces the four raw keys and the start switch. Each key press
//   becomes one direction command in a small FIFO, which drains to the control FSM
//   through a valid/ready handshake. A debounced start rising edge gives a one-cycle
//   start pulse and flushes the FIFO.
// Optional feature: define MOVE_REPEAT_EN to build key auto-repeat. While exactly one
//   key is held, it fires an extra event every REPEAT_CYCLES cycles.
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   key_n_i[3:0]   raw keys, active-low: [3]=up [2]=down [1]=left [0]=right
//   start_sw_i     raw start switch, active-high
//   dir_ready_i    consumer takes the head command this cycle
//   dir_valid_o    FIFO non-empty
//   direction_o    one-hot head command, same bit order as key_n_i; 0 when empty
//   start_pulse_o  one-cycle pulse on the debounced start rising edge
//   overflow_o     sticky: a press was dropped because the FIFO was full
//   fifo_count_o   occupied FIFO entries
module move_input_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned REPEAT_CYCLES   = 25000000
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [3:0]                    key_n_i,
   input  logic                          start_sw_i,
   input  logic                          dir_ready_i,
   output logic                          dir_valid_o,
   output logic [3:0]                    direction_o,
   output logic                          start_pulse_o,
   output logic                          overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(FIFO_DEPTH);

   // Synchroniser. Key stages reset to 1 (released) so reset release makes no phantom press.
   logic [4:0] sync1_q, sync2_q;
   logic [4:0] in_act;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 5'b01111;
         sync2_q <= 5'b01111;
      end else begin
         sync1_q <= {start_sw_i, key_n_i};
         sync2_q <= sync1_q;
      end
   end

   // Active-high view: [4]=start, [3:0]=key pressed.
   assign in_act = {sync2_q[4], ~sync2_q[3:0]};

   // Debounce: the stable value follows the synced value only after DEBOUNCE_CYCLES
   // consecutive cycles of disagreement.
   logic [4:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]            stable_q, upd;

   always_comb begin
      cnt_d = cnt_q;
      upd   = '0;
      for (int i = 0; i < 5; i++) begin
         if (in_act[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DbLast) begin
            upd[i]   = 1'b1;
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   logic [3:0] press_d, ev_d, ev_q;
   logic       start_pulse_q;

   assign press_d = upd[3:0] & in_act[3:0];

`ifdef MOVE_REPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_CYCLES) + 1;
   localparam logic [REP_W-1:0] RepLast = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [3:0]       rep_d;
   logic             one_key;

   assign one_key = (stable_q[3:0] != 4'd0) &&
                    ((stable_q[3:0] & (stable_q[3:0] - 4'd1)) == 4'd0);

   always_comb begin
      rep_d     = '0;
      rep_cnt_d = rep_cnt_q;
      if ((|upd) || !one_key) begin
         rep_cnt_d = '0;
      end else if (rep_cnt_q == RepLast) begin
         rep_cnt_d = '0;
         rep_d     = stable_q[3:0];
      end else begin
         rep_cnt_d = rep_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rep_cnt_q <= '0;
      else         rep_cnt_q <= rep_cnt_d;
   end

   assign ev_d = press_d | rep_d;
`else
   assign ev_d = press_d;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q         <= '0;
         stable_q      <= '0;
         ev_q          <= '0;
         start_pulse_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         stable_q      <= stable_q ^ upd;
         ev_q          <= ev_d;
         start_pulse_q <= upd[4] & in_act[4];
      end
   end

   // Simultaneous events: only the highest-priority one is queued, stored as its bit index.
   logic [1:0] push_code;

   always_comb begin
      push_code = 2'd0;
      if (ev_q[3])      push_code = 2'd3;
      else if (ev_q[2]) push_code = 2'd2;
      else if (ev_q[1]) push_code = 2'd1;
   end

   // Command FIFO
   logic [FIFO_DEPTH-1:0][1:0] mem_q;
   logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]             count_q;
   logic                       overflow_q;
   logic                       empty, full, push_req, push, pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FullCnt);
   assign push_req = |ev_q;
   assign pop      = !empty && dir_ready_i;
   // A pop from a full FIFO makes room in the same cycle; an empty FIFO never falls through.
   assign push     = push_req && (!full || pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (start_pulse_q) begin
         // New game: drop queued and in-flight commands.
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_code;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (!push && pop) count_q <= count_q - 1'b1;
         if (push_req && full && !pop) overflow_q <= 1'b1;
      end
   end

   assign dir_valid_o   = !empty;
   assign direction_o   = empty ? 4'b0000 : (4'b0001 << mem_q[rd_ptr_q]);
   assign start_pulse_o = start_pulse_q;
   assign overflow_o    = overflow_q;
   assign fifo_count_o  = count_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// tb_move_input_ctrl: directed bench for move_input_ctrl with short debounce/repeat periods.
// Inputs are driven and outputs sampled on the falling clock edge.
// With MOVE_REPEAT_EN defined, the held-key case expects the repeated commands.
module tb_move_input_ctrl;

   localparam int unsigned D = 4;
   localparam int unsigned R = 16;
`ifdef MOVE_REPEAT_EN
   localparam int unsigned ExpHeld = 3;
`else
   localparam int unsigned ExpHeld = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] key_n;
   logic       start_sw, dir_ready;
   logic       dir_valid, start_pulse, overflow;
   logic [3:0] direction;
   logic [2:0] fifo_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit seen;

   always #5 clk = ~clk;

   move_input_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (20),
      .FIFO_DEPTH     (4),
      .REPEAT_CYCLES  (R)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .key_n_i      (key_n),
      .start_sw_i   (start_sw),
      .dir_ready_i  (dir_ready),
      .dir_valid_o  (dir_valid),
      .direction_o  (direction),
      .start_pulse_o(start_pulse),
      .overflow_o   (overflow),
      .fifo_count_o (fifo_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_release(input logic [3:0] mask);
      key_n = ~mask;
      cyc(10);
      key_n = 4'hf;
      cyc(10);
   endtask

   initial begin
      rst_n     = 1'b0;
      key_n     = 4'hf;
      start_sw  = 1'b0;
      dir_ready = 1'b0;
      cyc(2);
      check_eq("rst_valid", dir_valid, 1'b0);
      check_eq("rst_dir", direction, 4'h0);
      check_eq("rst_start", start_pulse, 1'b0);
      check_eq("rst_ovf", overflow, 1'b0);
      check_eq("rst_count", fifo_count, 3'd0);
      rst_n = 1'b1;
      cyc(2);

      // Single up press: valid exactly at cycle D+3, consumed immediately.
      dir_ready = 1'b1;
      key_n     = 4'b0111;
      for (int k = 1; k <= 9; k++) begin
         cyc(1);
         check_eq($sformatf("lat_valid_c%0d", k), dir_valid, (k == 7));
         if (k == 7) check_eq("lat_dir", direction, 4'b1000);
      end
      key_n = 4'hf;
      seen  = 1'b0;
      repeat (20) begin
         cyc(1);
         if (dir_valid) seen = 1'b1;
      end
      check_eq("release_no_cmd", seen, 1'b0);

      // Bouncing left key, then a firm hold: one command only.
      dir_ready = 1'b0;
      repeat (3) begin
         key_n = 4'b1101;
         cyc(2);
         key_n = 4'hf;
         cyc(2);
      end
      key_n = 4'b1101;
      cyc(10);
      check_eq("bounce_count", fifo_count, 3'd1);
      check_eq("bounce_dir", direction, 4'b0010);
      key_n = 4'hf;
      cyc(10);
      check_eq("bounce_count2", fifo_count, 3'd1);
      dir_ready = 1'b1;
      cyc(1);
      check_eq("bounce_pop", fifo_count, 3'd0);

      // Overflow: five presses into a four-entry FIFO, then drain.
      dir_ready = 1'b0;
      repeat (5) press_release(4'b0010);
      check_eq("ovf_count", fifo_count, 3'd4);
      check_eq("ovf_flag", overflow, 1'b1);
      dir_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("drain_valid%0d", i), dir_valid, 1'b1);
         check_eq($sformatf("drain_dir%0d", i), direction, 4'b0010);
         cyc(1);
      end
      check_eq("drain_empty", dir_valid, 1'b0);
      check_eq("drain_count", fifo_count, 3'd0);
      check_eq("ovf_sticky", overflow, 1'b1);

      // Start switch: one-cycle pulse, flush and overflow clear on the following cycle.
      dir_ready = 1'b0;
      repeat (2) press_release(4'b0010);
      check_eq("pre_start_count", fifo_count, 3'd2);
      start_sw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         check_eq($sformatf("start_pulse_c%0d", k), start_pulse, (k == 6));
         if (k == 6) check_eq("start_count_hold", fifo_count, 3'd2);
         if (k == 7) begin
            check_eq("start_flush", fifo_count, 3'd0);
            check_eq("start_ovf_clr", overflow, 1'b0);
         end
      end
      start_sw = 1'b0;
      seen     = 1'b0;
      repeat (12) begin
         cyc(1);
         if (start_pulse) seen = 1'b1;
      end
      check_eq("start_fall_no_pulse", seen, 1'b0);

      // Asynchronous reset with two entries queued.
      repeat (2) press_release(4'b0100);
      check_eq("pre_rst_count", fifo_count, 3'd2);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_valid", dir_valid, 1'b0);
      check_eq("arst_dir", direction, 4'h0);
      check_eq("arst_count", fifo_count, 3'd0);
      check_eq("arst_ovf", overflow, 1'b0);
      check_eq("arst_start", start_pulse, 1'b0);
      cyc(1);
      rst_n = 1'b1;
      cyc(2);

      // Up and right on the same edge: only up is queued.
      key_n = 4'b0110;
      cyc(10);
      key_n = 4'hf;
      cyc(10);
      check_eq("prio_count", fifo_count, 3'd1);
      check_eq("prio_dir", direction, 4'b1000);
      dir_ready = 1'b1;
      cyc(1);
      dir_ready = 1'b0;
      check_eq("prio_pop", fifo_count, 3'd0);

      // Single key held 40 cycles: one command, or three with auto-repeat.
      key_n = 4'b0111;
      cyc(40);
      key_n = 4'hf;
      cyc(10);
      check_eq("held_count", fifo_count, 3'(ExpHeld));
      check_eq("held_dir", direction, 4'b1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
